// File: rtl/trojan_monitor.sv
// trojan_monitor: passive checker for a ready/valid buffer.
// It keeps a shadow copy of every accepted ingress word and compares it
// against the word leaving the buffer. Underflow, overflow and data corruption
// raise a sticky alarm, and the first fault cause is recorded.
// Optional feature: define TROJAN_MON_TIMEOUT_EN to add a stall watchdog
// (timeout fault, code 11). Without the macro the watchdog is not built.
module trojan_monitor #(
    parameter int DW      = 16,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid_i,
    input  logic          ready_o,
    input  logic [DW-1:0] din_i,
    input  logic          valid_o,
    input  logic          ready_i,
    input  logic [DW-1:0] dout_o,
    input  logic          clear_i,
    output logic          mismatch_p,
    output logic          alarm,
    output logic [1:0]    err_code,
    output logic [15:0]   beat_cnt,
    output logic [7:0]    fault_cnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        TRACK = 2'b01,
        ALARM = 2'b10
    } state_t;

    // Out-of-range parameters leave this marker block in the elaborated design.
    if (DEPTH < 2 || TIMEOUT < 2) begin : g_param_range_violation
    end

    state_t          r_state;
    state_t          w_state_next;
    logic [DW-1:0]   r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_mismatch_p;
    logic [1:0]      r_err_code;
    logic [15:0]     r_beat_cnt;
    logic [7:0]      r_fault_cnt;

    logic            w_in_beat;
    logic            w_eg_beat;
    logic            w_empty;
    logic            w_full;
    logic            w_underflow;
    logic            w_overflow;
    logic            w_push;
    logic            w_pop;
    logic            w_mismatch;
    logic            w_beat_fault;
    logic            w_timeout;
    logic            w_fault;
    logic [1:0]      w_code;
    logic [CW-1:0]   w_count_next;

    assign w_in_beat    = valid_i & ready_o;
    assign w_eg_beat    = valid_o & ready_i;
    assign w_empty      = (r_count == '0);
    assign w_full       = (r_count == CW'(DEPTH));
    // Egress on an empty shadow is an underflow even if a word arrives now.
    assign w_underflow  = w_eg_beat & w_empty;
    // A full shadow can still accept a word when the head leaves this cycle.
    assign w_overflow   = w_in_beat & w_full & ~w_eg_beat;
    assign w_pop        = w_eg_beat & ~w_empty;
    assign w_push       = w_in_beat & ~w_overflow;
    // A corrupted head is still consumed so tracking stays aligned.
    assign w_mismatch   = w_pop & (dout_o != r_mem[r_rd_ptr]);
    assign w_beat_fault = w_underflow | w_overflow | w_mismatch;
    assign w_fault      = w_beat_fault | w_timeout;
    assign w_code       = w_mismatch ? 2'b01 : (w_beat_fault ? 2'b10 : 2'b11);
    assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);

`ifdef TROJAN_MON_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT + 1);

    logic [WW-1:0] r_wdog;
    logic [WW-1:0] w_wdog_inc;
    logic          w_wdog_run;

    // Counts stalled cycles: words outstanding, consumer ready, nothing leaving.
    assign w_wdog_run = (r_state == TRACK) & ready_i & ~w_eg_beat;
    assign w_wdog_inc = r_wdog + WW'(1);
    assign w_timeout  = w_wdog_run & (w_wdog_inc == WW'(TIMEOUT));

    // Watchdog counter: reloads on timeout, zeroes on egress or outside TRACK.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wdog <= '0;
        end else if (clear_i) begin
            r_wdog <= '0;
        end else if (w_wdog_run) begin
            r_wdog <= w_timeout ? '0 : w_wdog_inc;
        end else begin
            r_wdog <= '0;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Shadow storage: written on accepted ingress, no reset needed on data.
    always_ff @(posedge clk) begin
        if (w_push && !clear_i) begin
            r_mem[r_wr_ptr] <= din_i;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state and alarm output; clear beats any fault in the same cycle.
    always_comb begin
        w_state_next = r_state;
        alarm        = (r_state == ALARM);
        if (clear_i) begin
            w_state_next = IDLE;
        end else if (w_fault) begin
            w_state_next = ALARM;
        end else begin
            case (r_state)
                IDLE:    if (w_count_next != '0) w_state_next = TRACK;
                TRACK:   if (w_count_next == '0) w_state_next = IDLE;
                ALARM:   w_state_next = ALARM;
                default: w_state_next = IDLE;
            endcase
        end
    end

    // Queue pointers, fault reporting and saturating counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_mismatch_p <= 1'b0;
            r_err_code   <= 2'b00;
            r_beat_cnt   <= '0;
            r_fault_cnt  <= '0;
        end else if (clear_i) begin
            // Counters are kept across a clear; only tracking state resets.
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_mismatch_p <= 1'b0;
            r_err_code   <= 2'b00;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count      <= w_count_next;
            r_mismatch_p <= w_fault;
            if (w_fault && r_err_code == 2'b00) begin
                r_err_code <= w_code;
            end
            if (w_eg_beat && r_beat_cnt != 16'hFFFF) begin
                r_beat_cnt <= r_beat_cnt + 16'd1;
            end
            if (w_fault && r_fault_cnt != 8'hFF) begin
                r_fault_cnt <= r_fault_cnt + 8'd1;
            end
        end
    end

    assign mismatch_p = r_mismatch_p;
    assign err_code   = r_err_code;
    assign beat_cnt   = r_beat_cnt;
    assign fault_cnt  = r_fault_cnt;

endmodule

// File: tb/tb_trojan_monitor.sv
// Bench for trojan_monitor: directed scenarios followed by random traffic,
// every cycle checked against a queue-based reference model.
module tb_trojan_monitor;

    localparam int DW      = 16;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_i, ready_o, valid_o, ready_i, clear_i;
    logic [DW-1:0] din_i, dout_o;
    logic          mismatch_p, alarm;
    logic [1:0]    err_code;
    logic [15:0]   beat_cnt;
    logic [7:0]    fault_cnt;

    trojan_monitor #(.DW(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .din_i      (din_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .dout_o     (dout_o),
        .clear_i    (clear_i),
        .mismatch_p (mismatch_p),
        .alarm      (alarm),
        .err_code   (err_code),
        .beat_cnt   (beat_cnt),
        .fault_cnt  (fault_cnt)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state
    int       m_q[$];
    int       m_beat;
    int       m_fault;
    int       m_err;
    bit       m_alarm;
    bit       m_mp;
    int       m_wd;
    int       m_cyc = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, m_cyc);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_beat  = 0;
        m_fault = 0;
        m_err   = 0;
        m_alarm = 0;
        m_mp    = 0;
        m_wd    = 0;
    endtask

    task automatic check_outputs();
        check_val("mismatch_p", {31'd0, mismatch_p}, {31'd0, m_mp});
        check_val("alarm",      {31'd0, alarm},      {31'd0, m_alarm});
        check_val("err_code",   {30'd0, err_code},   m_err);
        check_val("beat_cnt",   {16'd0, beat_cnt},   m_beat);
        check_val("fault_cnt",  {24'd0, fault_cnt},  m_fault);
    endtask

    // Advance the model by one clock for the given input values.
    task automatic model_step(input bit vi, input bit ro, input int di,
                              input bit vo, input bit ri, input int dq, input bit clr);
        bit in_b, eg_b, fault, was_track;
        int occ0, code, head;
        in_b  = vi && ro;
        eg_b  = vo && ri;
        fault = 0;
        code  = 0;
        if (clr) begin
            m_q.delete();
            m_alarm = 0;
            m_err   = 0;
            m_mp    = 0;
            m_wd    = 0;
            return;
        end
        occ0      = m_q.size();
        was_track = !m_alarm && occ0 > 0;
        if (eg_b) begin
            if (m_beat < 16'hFFFF) m_beat++;
            if (occ0 == 0) begin
                fault = 1; code = 2;
            end else begin
                head = m_q.pop_front();
                if (head != dq) begin
                    fault = 1; code = 1;
                end
            end
        end
        if (in_b) begin
            if (occ0 == DEPTH && !eg_b) begin
                fault = 1; code = 2;
            end else begin
                m_q.push_back(di);
            end
        end
`ifdef TROJAN_MON_TIMEOUT_EN
        if (was_track && ri && !eg_b) begin
            m_wd++;
            if (m_wd == TIMEOUT) begin
                m_wd = 0;
                if (!fault) code = 3;
                fault = 1;
            end
        end else begin
            m_wd = 0;
        end
`else
        if (was_track) m_wd = 0;
`endif
        m_mp = fault;
        if (fault) begin
            m_alarm = 1;
            if (m_fault < 255) m_fault++;
            if (m_err == 0) m_err = code;
        end
    endtask

    // Drive one cycle, clock it, then compare all outputs.
    task automatic step(input bit vi, input bit ro, input int di,
                        input bit vo, input bit ri, input int dq, input bit clr);
        valid_i = vi; ready_o = ro; din_i = DW'(di);
        valid_o = vo; ready_i = ri; dout_o = DW'(dq);
        clear_i = clr;
        model_step(vi, ro, di, vo, ri, dq, clr);
        @(posedge clk);
        #1;
        m_cyc++;
        if (vo && ri && !clr)
            $display("egress cyc=%0d dout=%04h mismatch_p=%0b err=%0d beats=%0d faults=%0d",
                     m_cyc, dq, mismatch_p, err_code, beat_cnt, fault_cnt);
        check_outputs();
    endtask

    task automatic idle_inputs();
        valid_i = 0; ready_o = 0; din_i = '0;
        valid_o = 0; ready_i = 0; dout_o = '0; clear_i = 0;
    endtask

    // Asynchronous reset applied away from the clock edge.
    task automatic apply_reset();
        idle_inputs();
        rst = 1'b0;
        #2;
        model_reset();
        check_outputs();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        #3;
        apply_reset();
        $display("reset checked");

        // In-order traffic: three words through, no fault.
        step(1, 1, 'hAAAA, 0, 0, 0, 0);
        step(1, 1, 'hBBBB, 0, 0, 0, 0);
        step(1, 1, 'hCCCC, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1, 'hAAAA, 0);
        step(0, 0, 0, 1, 1, 'hBBBB, 0);
        step(0, 0, 0, 1, 1, 'hCCCC, 0);
        check_val("inorder_beats", {16'd0, beat_cnt}, 3);
        check_val("inorder_alarm", {31'd0, alarm}, 0);
        check_val("inorder_err",   {30'd0, err_code}, 0);

        // Data mismatch, then underflow must not overwrite the code.
        step(1, 1, 'hDDDD, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1, 'h1234, 0);
        check_val("mm_pulse", {31'd0, mismatch_p}, 1);
        check_val("mm_err",   {30'd0, err_code}, 1);
        check_val("mm_fcnt",  {24'd0, fault_cnt}, 1);
        step(0, 0, 0, 0, 0, 0, 0);
        check_val("mm_pulse_end", {31'd0, mismatch_p}, 0);
        check_val("mm_alarm_sticky", {31'd0, alarm}, 1);
        step(0, 0, 0, 1, 1, 'h5555, 0);
        check_val("uf_keeps_err", {30'd0, err_code}, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        check_val("clr_alarm", {31'd0, alarm}, 0);

        // Overflow on the fifth push, then the four tracked words drain cleanly.
        for (int i = 0; i < 5; i++) step(1, 1, 'h1000 + i, 0, 0, 0, 0);
        check_val("ovf_err", {30'd0, err_code}, 2);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 1, 1, 'h1000 + i, 0);
            check_val("drain_no_fault", {31'd0, mismatch_p}, 0);
        end
        step(0, 0, 0, 0, 0, 0, 1);

        // Underflow with simultaneous ingress: the new word stays tracked.
        step(1, 1, 'hEEEE, 1, 1, 'hEEEE, 0);
        check_val("uf_in_err", {30'd0, err_code}, 2);
        step(0, 0, 0, 1, 1, 'hEEEE, 0);
        check_val("uf_in_tracked", {31'd0, mismatch_p}, 0);
        step(0, 0, 0, 1, 1, 'hEEEE, 0);
        check_val("uf_in_now_empty", {31'd0, mismatch_p}, 1);
        step(0, 0, 0, 0, 0, 0, 1);

        // Stall watchdog: consumer ready, nothing leaves for TIMEOUT cycles.
        step(1, 1, 'hBEEF, 0, 0, 0, 0);
        for (int i = 0; i < TIMEOUT; i++) step(0, 0, 0, 0, 1, 0, 0);
`ifdef TROJAN_MON_TIMEOUT_EN
        check_val("wdog_err",   {30'd0, err_code}, 3);
        check_val("wdog_alarm", {31'd0, alarm}, 1);
`else
        check_val("wdog_err",   {30'd0, err_code}, 0);
        check_val("wdog_alarm", {31'd0, alarm}, 0);
`endif
        step(0, 0, 0, 0, 0, 0, 1);

        // Reset mid-stream with two words tracked, then underflow and clear.
        step(1, 1, 'h0101, 0, 0, 0, 0);
        step(1, 1, 'h0202, 0, 0, 0, 0);
        apply_reset();
        step(0, 0, 0, 1, 1, 'h0101, 0);
        check_val("rst_uf_err", {30'd0, err_code}, 2);
        step(0, 0, 0, 0, 0, 0, 1);
        check_val("rst_clr_alarm", {31'd0, alarm}, 0);
        check_val("rst_clr_beats", {16'd0, beat_cnt}, 1);
        check_val("rst_clr_fcnt",  {24'd0, fault_cnt}, 1);

        // Random traffic; egress data is usually the expected head.
        for (int n = 0; n < 800; n++) begin
            bit vi, ro, vo, ri, clr;
            int di, dq;
            vi  = ($urandom_range(0, 99) < 55);
            ro  = ($urandom_range(0, 99) < 80);
            vo  = ($urandom_range(0, 99) < 50);
            ri  = ($urandom_range(0, 99) < 60);
            clr = ($urandom_range(0, 99) < 3);
            di  = int'($urandom_range(0, 16'hFFFF));
            if (m_q.size() > 0 && $urandom_range(0, 7) != 0) dq = m_q[0];
            else dq = int'($urandom_range(0, 16'hFFFF));
            step(vi, ro, di, vo, ri, dq, clr);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // Hard bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout_guard got=running exp=finished");
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/trojan_monitor.md
TROJAN_MONITOR -- requirements
Module: trojan_monitor

Interface
REQ-001 Parameters SHALL be: DW, 16, data width; DEPTH, 4, shadow-queue entries (power of two, >=2); TIMEOUT, 32, stall-watchdog cycles (>=2).
REQ-002 Ports SHALL be as follows, one per line: name  direction  width  meaning.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst  in  1  reset; asynchronous and active-low.
REQ-005 valid_i  in  1  tap of the monitored buffer's input valid.
REQ-006 ready_o  in  1  tap of the monitored buffer's input ready (monitor never drives it).
REQ-007 din_i  in  DW  tap of the monitored buffer's input data.
REQ-008 valid_o  in  1  tap of the monitored buffer's output valid.
REQ-009 ready_i  in  1  tap of the consumer's ready.
REQ-010 dout_o  in  DW  tap of the monitored buffer's output data.
REQ-011 clear_i  in  1  synchronous clear of alarm and shadow queue.
REQ-012 mismatch_p  out  1  one-cycle pulse per faulty egress beat.
REQ-013 alarm  out  1  sticky fault flag.
REQ-014 err_code  out  2  first fault cause: 00 none, 01 data mismatch, 10 underflow/overflow, 11 timeout.
REQ-015 beat_cnt  out  16  accepted egress beats, saturating at 16'hFFFF.
REQ-016 fault_cnt  out  8  faulty events, saturating at 8'hFF.

Function
REQ-017 Ingress beat = valid_i && ready_o; egress beat = valid_o && ready_i.
REQ-018 Ingress beat SHALL push din_i into the shadow queue; egress beat SHALL pop the head and compare with dout_o.
REQ-019 Simultaneous ingress and egress SHALL push and pop in the same cycle, occupancy unchanged; pointers SHALL wrap modulo DEPTH.
REQ-020 Egress beat with shadow empty (including when ingress occurs in the same cycle) SHALL be an underflow fault, code 10; nothing is popped.
REQ-021 Ingress beat with shadow full and no egress SHALL be an overflow fault, code 10; the word is discarded.
REQ-022 Egress beat with dout_o != head SHALL be a mismatch fault, code 01; the head is still popped.
REQ-023 A fault SHALL assert mismatch_p and alarm on the cycle after the faulting beat (one-cycle latency), and increment fault_cnt in that same cycle.
REQ-024 err_code SHALL latch only the first fault after reset/clear; later faults SHALL not overwrite it.
REQ-025 The FSM SHALL have states IDLE (shadow empty), TRACK (shadow non-empty), and ALARM (sticky).
REQ-026 IDLE->TRACK on a push. TRACK->IDLE when the last entry pops with no push. Any state->ALARM on a fault. ALARM->IDLE only on clear_i.
REQ-027 In ALARM the shadow queue and counters SHALL continue to operate; alarm stays 1.
REQ-028 Each non-faulty or faulty egress beat SHALL increment beat_cnt.
REQ-029 clear_i SHALL empty the shadow queue, deassert alarm, zero err_code, and return to IDLE; counters SHALL be retained.
REQ-030 clear_i coincident with a beat SHALL take priority; that beat is ignored.

Reset
REQ-031 rst low SHALL asynchronously force: FSM IDLE, shadow empty, mismatch_p 0, alarm 0, err_code 00, beat_cnt 0, fault_cnt 0, watchdog 0.
REQ-032 Reset assertion mid-traffic SHALL discard all tracked words; the first egress after release with empty shadow is an underflow.

Configuration
REQ-033 Macro TROJAN_MON_TIMEOUT_EN defined: a watchdog counts cycles in TRACK with ready_i=1 and no egress beat; reaching TIMEOUT SHALL raise a timeout fault (code 11, fault_cnt +1) and reload the watchdog to 0; any egress beat or leaving TRACK zeroes it.
REQ-034 Macro TROJAN_MON_TIMEOUT_EN undefined: no watchdog logic; code 11 is never produced.

Verification
REQ-035 Push 16'hAAAA, 16'hBBBB, 16'hCCCC, then receive them in order -> beat_cnt=3, alarm=0, err_code=00.
REQ-036 Push 16'hDDDD, then egress 16'h1234 -> mismatch_p one pulse the next cycle, alarm=1, err_code=01, fault_cnt=1; a later underflow leaves err_code=01.
REQ-037 DEPTH=4: push 5 words with ready_i=0 -> overflow on the 5th push, err_code=10; the 4 words drain correctly afterwards.
REQ-038 Egress beat at empty with simultaneous ingress of 16'hEEEE -> underflow, code 10; 16'hEEEE remains tracked (occupancy 1).
REQ-039 With TROJAN_MON_TIMEOUT_EN and TIMEOUT=32: push 16'hBEEF, hold ready_i=1, valid_o=0 for 32 cycles -> err_code=11, alarm=1; without the macro -> no fault.
REQ-040 Assert rst low mid-stream with 2 words tracked, then clear_i during ALARM -> all outputs at reset values; after clear_i, alarm=0 and counters unchanged.
